id_issue_ctrl: RTL and testbench

ID-stage issue controller: decides each cycle whether the decoded instruction in ID advances to EX, inserts a one-cycle bubble on load-use hazards and kills ID on taken jumps/branches from EX. It also sequences the two multi-cycle system instructions. For fence.i it drains the pipeline, handshakes an I-cache invalidate and then forces a refetch. For wfi it sleeps the front end until an interrupt is pending. It sits between the decoder outputs and the ID/EX pipeline register; the `stall_ld` it drives is the signal that masks `cmd_*` into EX.

---
 rtl/id_issue_ctrl.sv | 106 ++++++++++
 tb/tb_id_issue_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_ctrl.sv
// ID-stage issue control: load-use bubble, jump kill, and the fence.i / wfi
// sequencer that holds the front end while the pipeline drains or sleeps.
module id_issue_ctrl #(
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic       cmd_ld,
    input  logic       cmd_fencei,
    input  logic       cmd_wfi,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] inst_rs1,
    input  logic [4:0] inst_rs2,
    input  logic [4:0] rd_adr,
    input  logic       wbk_rd_reg,
    input  logic       jmp_flush,
    input  logic       irq_pending,
    input  logic       inv_ack,
    output logic       id_issue,
    output logic       stall_ld,
    output logic       stall_if,
    output logic       flush_id,
    output logic       inv_req,
    output logic       refetch,
    output logic       wfi_sleep
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_INV,
        ST_WFI
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_ld_vld;
    logic [4:0] r_ld_rd;

    logic w_run;
    logic w_hazard;
    logic w_ld_set;

    assign w_run    = (r_state == ST_RUN);
    // x0 loads are never captured, so a reader of x0 cannot match here
    assign w_hazard = r_ld_vld & id_valid &
                      ((use_rs1 & (inst_rs1 == r_ld_rd)) |
                       (use_rs2 & (inst_rs2 == r_ld_rd)));

    assign stall_ld  = w_hazard & ~jmp_flush & w_run;
    assign id_issue  = id_valid & w_run & ~stall_ld & ~jmp_flush;
    assign refetch   = (r_state == ST_INV) & inv_ack;
    assign flush_id  = jmp_flush | refetch;
    assign stall_if  = stall_ld | ~w_run;
    assign inv_req   = (r_state == ST_INV);
    assign wfi_sleep = (r_state == ST_WFI);

    assign w_ld_set = id_issue & cmd_ld & wbk_rd_reg & (rd_adr != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_cnt    <= 4'd0;
            r_ld_vld <= 1'b0;
            r_ld_rd  <= 5'd0;
        end else begin
            r_ld_vld <= w_ld_set;
            if (w_ld_set) begin
                r_ld_rd <= rd_adr;
            end
            case (r_state)
                ST_RUN: begin
                    if (id_issue & cmd_fencei) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= DRAIN_INIT;
                    end else if (id_issue & cmd_wfi) begin
                        r_state <= ST_WFI;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_INV;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_INV: begin
                    if (inv_ack) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_WFI: begin
                    if (irq_pending) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: two instances (drain of 3 and 1 cycles) share one
// stimulus stream; directed scenarios plus a random run against a cycle model.
module tb_id_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic       cmd_ld = 1'b0;
    logic       cmd_fencei = 1'b0;
    logic       cmd_wfi = 1'b0;
    logic       use_rs1 = 1'b0;
    logic       use_rs2 = 1'b0;
    logic [4:0] inst_rs1 = 5'd0;
    logic [4:0] inst_rs2 = 5'd0;
    logic [4:0] rd_adr = 5'd0;
    logic       wbk_rd_reg = 1'b0;
    logic       jmp_flush = 1'b0;
    logic       irq_pending = 1'b0;
    logic       inv_ack = 1'b0;

    logic a_issue, a_stall_ld, a_stall_if, a_flush, a_inv_req, a_refetch, a_sleep;
    logic b_issue, b_stall_ld, b_stall_if, b_flush, b_inv_req, b_refetch, b_sleep;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_issue_ctrl #(.DRAIN_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .cmd_ld(cmd_ld),
        .cmd_fencei(cmd_fencei), .cmd_wfi(cmd_wfi), .use_rs1(use_rs1),
        .use_rs2(use_rs2), .inst_rs1(inst_rs1), .inst_rs2(inst_rs2),
        .rd_adr(rd_adr), .wbk_rd_reg(wbk_rd_reg), .jmp_flush(jmp_flush),
        .irq_pending(irq_pending), .inv_ack(inv_ack),
        .id_issue(a_issue), .stall_ld(a_stall_ld), .stall_if(a_stall_if),
        .flush_id(a_flush), .inv_req(a_inv_req), .refetch(a_refetch),
        .wfi_sleep(a_sleep)
    );

    id_issue_ctrl #(.DRAIN_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .cmd_ld(cmd_ld),
        .cmd_fencei(cmd_fencei), .cmd_wfi(cmd_wfi), .use_rs1(use_rs1),
        .use_rs2(use_rs2), .inst_rs1(inst_rs1), .inst_rs2(inst_rs2),
        .rd_adr(rd_adr), .wbk_rd_reg(wbk_rd_reg), .jmp_flush(jmp_flush),
        .irq_pending(irq_pending), .inv_ack(inv_ack),
        .id_issue(b_issue), .stall_ld(b_stall_ld), .stall_if(b_stall_if),
        .flush_id(b_flush), .inv_req(b_inv_req), .refetch(b_refetch),
        .wfi_sleep(b_sleep)
    );

    // Output vector order: {id_issue, stall_ld, stall_if, flush_id, inv_req, refetch, wfi_sleep}
    logic [6:0] act3, act1;
    assign act3 = {a_issue, a_stall_ld, a_stall_if, a_flush, a_inv_req, a_refetch, a_sleep};
    assign act1 = {b_issue, b_stall_ld, b_stall_if, b_flush, b_inv_req, b_refetch, b_sleep};

    // Reference model: mode, drain cycles left, register still being loaded (-1 = none)
    localparam int M_RUN = 0, M_DRAIN = 1, M_INV = 2, M_WFI = 3;
    int drain_len [2] = '{3, 1};
    int m_mode [2];
    int m_left [2];
    int m_ld_rd [2];

    function automatic logic [6:0] exp_vec(input int k);
        bit run, dep, sld, iss, rf;
        run = (m_mode[k] == M_RUN);
        dep = id_valid && (m_ld_rd[k] >= 0) &&
              ((use_rs1 && int'(inst_rs1) == m_ld_rd[k]) ||
               (use_rs2 && int'(inst_rs2) == m_ld_rd[k]));
        sld = dep && !jmp_flush && run;
        iss = id_valid && run && !sld && !jmp_flush;
        rf  = (m_mode[k] == M_INV) && inv_ack;
        return {iss, sld, sld || !run, jmp_flush || rf,
                m_mode[k] == M_INV, rf, m_mode[k] == M_WFI};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_mode[k]  = M_RUN;
                m_left[k]  = 0;
                m_ld_rd[k] = -1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [6:0] e;
                int nld;
                e = exp_vec(k);
                nld = (e[6] && cmd_ld && wbk_rd_reg && rd_adr != 5'd0) ? int'(rd_adr) : -1;
                case (m_mode[k])
                    M_RUN: begin
                        if (e[6] && cmd_fencei) begin
                            m_mode[k] = M_DRAIN;
                            m_left[k] = drain_len[k];
                        end else if (e[6] && cmd_wfi) begin
                            m_mode[k] = M_WFI;
                        end
                    end
                    M_DRAIN: begin
                        m_left[k] = m_left[k] - 1;
                        if (m_left[k] == 0) m_mode[k] = M_INV;
                    end
                    M_INV: if (inv_ack) m_mode[k] = M_RUN;
                    default: if (irq_pending) m_mode[k] = M_RUN;
                endcase
                m_ld_rd[k] = nld;
            end
        end
    end

    task automatic set_inst(input bit v, input bit ld, input bit fi, input bit wf,
                            input bit u1, input bit u2, input int r1, input int r2,
                            input int rd, input bit wb);
        id_valid   = v;
        cmd_ld     = ld;
        cmd_fencei = fi;
        cmd_wfi    = wf;
        use_rs1    = u1;
        use_rs2    = u2;
        inst_rs1   = 5'(r1);
        inst_rs2   = 5'(r2);
        rd_adr     = 5'(rd);
        wbk_rd_reg = wb;
    endtask

    task automatic set_plain();
        set_inst(1, 0, 0, 0, 1, 1, 1, 2, 3, 1);
    endtask

    task automatic set_side(input bit jf, input bit irq, input bit ack);
        jmp_flush   = jf;
        irq_pending = irq;
        inv_ack     = ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_side(0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_side(0, 0, 0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (act3 !== 7'b0 || act1 !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_during got3=%b got1=%b exp=0000000", act3, act1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (act3 !== 7'b0 || act1 !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_after[%0d] got3=%b got1=%b exp=0000000", i, act3, act1);
            end
            @(negedge clk);
        end
    endtask

    // Load x5, then a consumer via rs1 (pass 0) or rs2 (pass 1): one bubble only
    task automatic test_load_use();
        logic [6:0] exp_s [3] = '{7'b1000000, 7'b0110000, 7'b1000000};
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                if (i == 0) set_inst(1, 1, 0, 0, 1, 0, 1, 0, 5, 1);
                else if (p == 0) set_inst(1, 0, 0, 0, 1, 1, 5, 7, 6, 1);
                else set_inst(1, 0, 0, 0, 1, 1, 7, 5, 6, 1);
                #1;
                n_checks++;
                if (act3 !== exp_s[i] || act1 !== exp_s[i]) begin
                    n_fail++;
                    $display("FAIL load_use p%0d c%0d got3=%b got1=%b exp=%b", p, i, act3, act1, exp_s[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_no_false_stall();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_inst(1, 1, 0, 0, 1, 0, 1, 0, 0, 1);
                1: set_inst(1, 0, 0, 0, 1, 1, 0, 0, 6, 1);
                2: set_inst(1, 1, 0, 0, 1, 0, 1, 0, 5, 1);
                default: set_inst(1, 0, 0, 0, 0, 0, 5, 5, 6, 1);
            endcase
            #1;
            n_checks++;
            if (act3 !== 7'b1000000 || act1 !== 7'b1000000) begin
                n_fail++;
                $display("FAIL no_false_stall c%0d got3=%b got1=%b exp=1000000", i, act3, act1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_priority();
        logic [6:0] exp_s [3] = '{7'b1000000, 7'b0001000, 7'b1000000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_inst(1, 1, 0, 0, 1, 0, 1, 0, 5, 1);
            else set_inst(1, 0, 0, 0, 1, 1, 5, 7, 6, 1);
            set_side(i == 1, 0, 0);
            #1;
            n_checks++;
            if (act3 !== exp_s[i] || act1 !== exp_s[i]) begin
                n_fail++;
                $display("FAIL flush_priority c%0d got3=%b got1=%b exp=%b", i, act3, act1, exp_s[i]);
            end
            @(negedge clk);
        end
        set_side(0, 0, 0);
    endtask

    // Pass 0: ack at T+6 only. Pass 1: ack in the first INV cycle of each instance.
    task automatic test_fencei();
        logic [6:0] e3 [2][8] = '{
            '{7'b1000000, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010100, 7'b0010100, 7'b0011110, 7'b1000000},
            '{7'b1000000, 7'b0010000, 7'b0010000, 7'b0010000, 7'b0011110, 7'b1000000, 7'b1000000, 7'b1000000}};
        logic [6:0] e1 [2][8] = '{
            '{7'b1000000, 7'b0010000, 7'b0010100, 7'b0010100, 7'b0010100, 7'b0010100, 7'b0011110, 7'b1000000},
            '{7'b1000000, 7'b0010000, 7'b0011110, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
        bit ack_s [2][8] = '{'{0, 0, 0, 0, 0, 0, 1, 0}, '{0, 0, 1, 0, 1, 0, 0, 0}};
        for (int p = 0; p < 2; p++) begin
            do_reset();
            for (int i = 0; i < 8; i++) begin
                if (i == 0) set_inst(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
                else set_plain();
                set_side(0, 0, ack_s[p][i]);
                #1;
                n_checks++;
                if (act3 !== e3[p][i]) begin
                    n_fail++;
                    $display("FAIL fencei_d3 p%0d T+%0d got=%b exp=%b", p, i, act3, e3[p][i]);
                end
                n_checks++;
                if (act1 !== e1[p][i]) begin
                    n_fail++;
                    $display("FAIL fencei_d1 p%0d T+%0d got=%b exp=%b", p, i, act1, e1[p][i]);
                end
                @(negedge clk);
            end
        end
        set_side(0, 0, 0);
    endtask

    task automatic test_wfi();
        logic [6:0] e [6] = '{7'b1000000, 7'b0011001, 7'b0010001, 7'b0010001, 7'b0010001, 7'b1000000};
        bit jf_s [6]  = '{0, 1, 0, 0, 0, 0};
        bit ack_s [6] = '{0, 0, 1, 0, 0, 0};
        bit irq_s [6] = '{0, 0, 0, 0, 1, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) set_inst(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            else set_plain();
            set_side(jf_s[i], irq_s[i], ack_s[i]);
            #1;
            n_checks++;
            if (act3 !== e[i] || act1 !== e[i]) begin
                n_fail++;
                $display("FAIL wfi_sleep c%0d got3=%b got1=%b exp=%b", i, act3, act1, e[i]);
            end
            @(negedge clk);
        end
        // irq already pending at issue: exactly one sleep cycle
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_inst(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            else set_plain();
            set_side(0, 1, 0);
            #1;
            n_checks++;
            if (act3 !== ((i == 1) ? 7'b0010001 : 7'b1000000)) begin
                n_fail++;
                $display("FAIL wfi_irq_early c%0d got=%b", i, act3);
            end
            @(negedge clk);
        end
        set_side(0, 0, 0);
    endtask

    task automatic test_reset_mid_inv();
        do_reset();
        set_inst(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        set_plain();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (a_inv_req !== 1'b1 || b_inv_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_inv_reached got3=%b got1=%b exp=1", a_inv_req, b_inv_req);
        end
        set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (act3 !== 7'b0 || act1 !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_inv_reset got3=%b got1=%b exp=0000000", act3, act1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_plain();
        #1;
        n_checks++;
        if (act3 !== 7'b1000000 || act1 !== 7'b1000000) begin
            n_fail++;
            $display("FAIL mid_inv_release got3=%b got1=%b exp=1000000", act3, act1);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int regs [4] = '{0, 1, 2, 5};
        logic [6:0] e3, e1;
        int kind;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            kind = $urandom_range(15);
            set_inst($urandom_range(7) != 0, kind < 5, kind == 5, kind == 6,
                     $urandom_range(3) != 0, $urandom_range(1) == 1,
                     regs[$urandom_range(3)], regs[$urandom_range(3)],
                     regs[$urandom_range(3)], $urandom_range(7) != 0);
            set_side($urandom_range(9) == 0, $urandom_range(5) == 0, $urandom_range(3) == 0);
            #1;
            e3 = exp_vec(0);
            e1 = exp_vec(1);
            n_checks++;
            if (act3 !== e3) begin
                n_fail++;
                $display("FAIL random_d3 c%0d got=%b exp=%b", c, act3, e3);
            end
            n_checks++;
            if (act1 !== e1) begin
                n_fail++;
                $display("FAIL random_d1 c%0d got=%b exp=%b", c, act1, e1);
            end
            @(negedge clk);
        end
        set_side(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_fencei();
        test_wfi();
        test_reset_mid_inv();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
